kf_stream_decoder: RTL and testbench

Parses a KryoFlux-format stream byte sequence back into flux intervals and out-of-band (OOB) events. It is the decode counterpart of the `kf_protocol` stream encoder. It sits on the host-to-device write path and in loopback self-test, where encoder output is fed straight back through it. Stream-position fields in OOB blocks are cross-checked against a locally maintained byte count.

---
 rtl/kf_stream_decoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_kf_stream_decoder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_stream_decoder.sv
// ============================================================================
// kf_stream_decoder
// ----------------------------------------------------------------------------
// Purpose:
//   Turns a KryoFlux-format stream byte sequence back into flux intervals and
//   out-of-band (OOB) events. This is the decode counterpart of the stream
//   encoder. It is used on the host-to-device write path and in loopback
//   self-test. Stream-position fields carried in OOB blocks can be
//   cross-checked against a locally kept count of non-OOB bytes.
//
// Configuration macro:
//   KF_DEC_POS_CHECK_EN - when defined, builds the OOB stream-position
//                         comparator that drives pos_error. When undefined,
//                         pos_error is tied low.
//
// Parameters:
//   FLUX_W           width of the decoded flux interval (must be >= 17 so
//                    that one Ovl16 step of 0x10000 fits)
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   dec_clear        synchronous clear: back to HDR, counters and flags zeroed
//   in_data[7:0]     stream byte
//   in_valid         stream byte valid
//   in_ready         byte accepted when in_valid && in_ready
//   flux_out_data    decoded flux interval, in sample clocks
//   flux_out_valid   flux word valid, held until accepted
//   flux_out_ready   downstream accept
//   oob_valid        one-cycle pulse when an OOB block completes
//   oob_type         OOB type byte
//   oob_len          OOB payload size
//   oob_word0..2     little-endian words from payload bytes 0-3, 4-7, 8-11
//   stream_position  count of non-OOB bytes accepted (wraps mod 2^32)
//   index_count      number of Index OOBs seen (wraps mod 2^16)
//   stream_done      EOF OOB received
//   pos_error        sticky: OOB position field disagreed with local count
//   ovf_error        sticky: flux accumulator overflow (output saturated)
//
// State table:
//   state        | meaning
//   S_HDR        | waiting for a block header byte
//   S_F2_LO      | Flux2: waiting for the low byte
//   S_F3_HI      | Flux3: waiting for the high byte
//   S_F3_LO      | Flux3: waiting for the low byte
//   S_NOP        | Nop2/Nop3: skipping r_skip filler bytes
//   S_OOB_TYPE   | OOB: waiting for the type byte
//   S_OOB_SZ_LO  | OOB: waiting for the size low byte
//   S_OOB_SZ_HI  | OOB: waiting for the size high byte
//   S_OOB_PAY    | OOB: consuming payload bytes
//   S_DONE       | EOF seen: every byte is discarded until clear/reset
// ============================================================================
module kf_stream_decoder #(
    parameter int FLUX_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_clear,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FLUX_W-1:0] flux_out_data,
    output logic              flux_out_valid,
    input  logic              flux_out_ready,
    output logic              oob_valid,
    output logic [7:0]        oob_type,
    output logic [15:0]       oob_len,
    output logic [31:0]       oob_word0,
    output logic [31:0]       oob_word1,
    output logic [31:0]       oob_word2,
    output logic [31:0]       stream_position,
    output logic [15:0]       index_count,
    output logic              stream_done,
    output logic              pos_error,
    output logic              ovf_error
);

    typedef enum logic [3:0] {
        S_HDR,
        S_F2_LO,
        S_F3_HI,
        S_F3_LO,
        S_NOP,
        S_OOB_TYPE,
        S_OOB_SZ_LO,
        S_OOB_SZ_HI,
        S_OOB_PAY,
        S_DONE
    } state_t;

    localparam logic [FLUX_W:0] OVL_STEP = (FLUX_W+1)'(32'h0001_0000);
    localparam logic [7:0]      T_EOF    = 8'h0D;

    state_t            r_state;
    logic [2:0]        r_hdr_lo;
    logic [7:0]        r_f3_hi;
    logic [1:0]        r_skip;
    logic [FLUX_W-1:0] r_ovl_acc;
    logic              r_ovl_sat;
    logic [7:0]        r_cur_type;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_cur_len;
    logic [15:0]       r_pay_cnt;
    logic [31:0]       r_cur_w0;
    logic [31:0]       r_cur_w1;
    logic [31:0]       r_cur_w2;

    logic [FLUX_W-1:0] r_flux_data;
    logic              r_flux_valid;
    logic              r_oob_valid;
    logic [7:0]        r_oob_type;
    logic [15:0]       r_oob_len;
    logic [31:0]       r_oob_w0;
    logic [31:0]       r_oob_w1;
    logic [31:0]       r_oob_w2;
    logic [31:0]       r_stream_position;
    logic [15:0]       r_index_count;
    logic              r_stream_done;
    logic              r_pos_error;
    logic              r_ovf_error;

    logic              w_accept;
    logic              w_flux_fire;
    logic [15:0]       w_flux_val;
    logic [FLUX_W:0]   w_sum;
    logic [FLUX_W:0]   w_ovl_sum;
    logic              w_pos_inc;
    logic [31:0]       w_w0;
    logic [31:0]       w_w1;
    logic [31:0]       w_w2;
    logic [15:0]       w_done_len;
    logic              w_oob_done;
    logic              w_eof_done;
    logic              w_pos_mismatch;

    // A pending flux word that is not being taken this cycle blocks input;
    // a clear cycle also refuses the byte so it cannot leak past the clear.
    assign in_ready = rst_n && !(r_flux_valid && !flux_out_ready) && !dec_clear;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_flux_fire = 1'b0;
        w_flux_val  = 16'h0000;
        if (w_accept) begin
            case (r_state)
                S_HDR: begin
                    if (in_data >= 8'h0E) begin
                        w_flux_fire = 1'b1;
                        w_flux_val  = {8'h00, in_data};
                    end
                end
                S_F2_LO: begin
                    w_flux_fire = 1'b1;
                    w_flux_val  = {5'b00000, r_hdr_lo, in_data};
                end
                S_F3_LO: begin
                    w_flux_fire = 1'b1;
                    w_flux_val  = {r_f3_hi, in_data};
                end
                default: ;
            endcase
        end
    end

    // One spare bit catches a carry out of the FLUX_W-wide result.
    assign w_sum     = {1'b0, r_ovl_acc} + (FLUX_W+1)'(w_flux_val);
    assign w_ovl_sum = {1'b0, r_ovl_acc} + OVL_STEP;

    always_comb begin
        w_pos_inc = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_HDR:                               w_pos_inc = (in_data != 8'h0D);
                S_F2_LO, S_F3_HI, S_F3_LO, S_NOP:    w_pos_inc = 1'b1;
                default:                             w_pos_inc = 1'b0;
            endcase
        end
    end

    // Shadow payload words with the byte currently on in_data merged in, so a
    // completing payload byte is visible in the published words.
    always_comb begin
        w_w0 = r_cur_w0;
        w_w1 = r_cur_w1;
        w_w2 = r_cur_w2;
        if (r_state == S_OOB_PAY && r_pay_cnt < 16'd12) begin
            case (r_pay_cnt[3:2])
                2'd0:    w_w0[{r_pay_cnt[1:0], 3'b000} +: 8] = in_data;
                2'd1:    w_w1[{r_pay_cnt[1:0], 3'b000} +: 8] = in_data;
                default: w_w2[{r_pay_cnt[1:0], 3'b000} +: 8] = in_data;
            endcase
        end
    end

    assign w_done_len = (r_state == S_OOB_SZ_HI) ? {in_data, r_len_lo} : r_cur_len;

    assign w_eof_done = w_accept && (r_state == S_OOB_SZ_HI) && (r_cur_type == T_EOF);
    assign w_oob_done = w_accept && (r_cur_type != T_EOF) &&
                        (((r_state == S_OOB_SZ_HI) && ({in_data, r_len_lo} == 16'h0000)) ||
                         ((r_state == S_OOB_PAY) && (r_pay_cnt == r_cur_len - 16'd1)));

`ifdef KF_DEC_POS_CHECK_EN
    // OOB bytes never advance the position, so the registered count is the
    // position the block refers to.
    assign w_pos_mismatch = w_oob_done &&
                            (r_cur_type == 8'h01 || r_cur_type == 8'h02 || r_cur_type == 8'h03) &&
                            (w_done_len >= 16'd4) && (w_w0 != r_stream_position);
`else
    assign w_pos_mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_HDR;
            r_hdr_lo          <= '0;
            r_f3_hi           <= '0;
            r_skip            <= '0;
            r_ovl_acc         <= '0;
            r_ovl_sat         <= 1'b0;
            r_cur_type        <= '0;
            r_len_lo          <= '0;
            r_cur_len         <= '0;
            r_pay_cnt         <= '0;
            r_cur_w0          <= '0;
            r_cur_w1          <= '0;
            r_cur_w2          <= '0;
            r_flux_data       <= '0;
            r_flux_valid      <= 1'b0;
            r_oob_valid       <= 1'b0;
            r_oob_type        <= '0;
            r_oob_len         <= '0;
            r_oob_w0          <= '0;
            r_oob_w1          <= '0;
            r_oob_w2          <= '0;
            r_stream_position <= '0;
            r_index_count     <= '0;
            r_stream_done     <= 1'b0;
            r_pos_error       <= 1'b0;
            r_ovf_error       <= 1'b0;
        end else if (dec_clear) begin
            r_state           <= S_HDR;
            r_hdr_lo          <= '0;
            r_f3_hi           <= '0;
            r_skip            <= '0;
            r_ovl_acc         <= '0;
            r_ovl_sat         <= 1'b0;
            r_cur_type        <= '0;
            r_len_lo          <= '0;
            r_cur_len         <= '0;
            r_pay_cnt         <= '0;
            r_cur_w0          <= '0;
            r_cur_w1          <= '0;
            r_cur_w2          <= '0;
            r_flux_data       <= '0;
            r_flux_valid      <= 1'b0;
            r_oob_valid       <= 1'b0;
            r_oob_type        <= '0;
            r_oob_len         <= '0;
            r_oob_w0          <= '0;
            r_oob_w1          <= '0;
            r_oob_w2          <= '0;
            r_stream_position <= '0;
            r_index_count     <= '0;
            r_stream_done     <= 1'b0;
            r_pos_error       <= 1'b0;
            r_ovf_error       <= 1'b0;
        end else begin
            r_oob_valid <= 1'b0;

            if (r_flux_valid && flux_out_ready) begin
                r_flux_valid <= 1'b0;
            end
            // A new word may land in the same cycle the old one is taken.
            if (w_flux_fire) begin
                r_flux_valid <= 1'b1;
                if (w_sum[FLUX_W] || r_ovl_sat) begin
                    r_flux_data <= '1;
                    r_ovf_error <= 1'b1;
                end else begin
                    r_flux_data <= w_sum[FLUX_W-1:0];
                end
                r_ovl_acc <= '0;
                r_ovl_sat <= 1'b0;
            end

            if (w_pos_inc) begin
                r_stream_position <= r_stream_position + 32'd1;
            end

            if (w_accept) begin
                case (r_state)
                    S_HDR: begin
                        if (in_data <= 8'h07) begin
                            r_hdr_lo <= in_data[2:0];
                            r_state  <= S_F2_LO;
                        end else if (in_data == 8'h09) begin
                            r_skip  <= 2'd1;
                            r_state <= S_NOP;
                        end else if (in_data == 8'h0A) begin
                            r_skip  <= 2'd2;
                            r_state <= S_NOP;
                        end else if (in_data == 8'h0B) begin
                            // Saturate the accumulator once it has carried out.
                            r_ovl_acc <= w_ovl_sum[FLUX_W-1:0];
                            if (w_ovl_sum[FLUX_W]) begin
                                r_ovl_sat <= 1'b1;
                            end
                        end else if (in_data == 8'h0C) begin
                            r_state <= S_F3_HI;
                        end else if (in_data == 8'h0D) begin
                            r_state <= S_OOB_TYPE;
                        end
                    end
                    S_F2_LO: r_state <= S_HDR;
                    S_F3_HI: begin
                        r_f3_hi <= in_data;
                        r_state <= S_F3_LO;
                    end
                    S_F3_LO: r_state <= S_HDR;
                    S_NOP: begin
                        r_skip <= r_skip - 2'd1;
                        if (r_skip == 2'd1) begin
                            r_state <= S_HDR;
                        end
                    end
                    S_OOB_TYPE: begin
                        r_cur_type <= in_data;
                        r_pay_cnt  <= '0;
                        r_cur_w0   <= '0;
                        r_cur_w1   <= '0;
                        r_cur_w2   <= '0;
                        r_state    <= S_OOB_SZ_LO;
                    end
                    S_OOB_SZ_LO: begin
                        r_len_lo <= in_data;
                        r_state  <= S_OOB_SZ_HI;
                    end
                    S_OOB_SZ_HI: begin
                        r_cur_len <= {in_data, r_len_lo};
                        if (r_cur_type == T_EOF) begin
                            r_state <= S_DONE;
                        end else if ({in_data, r_len_lo} == 16'h0000) begin
                            r_state <= S_HDR;
                        end else begin
                            r_state <= S_OOB_PAY;
                        end
                    end
                    S_OOB_PAY: begin
                        r_cur_w0  <= w_w0;
                        r_cur_w1  <= w_w1;
                        r_cur_w2  <= w_w2;
                        r_pay_cnt <= r_pay_cnt + 16'd1;
                        if (r_pay_cnt == r_cur_len - 16'd1) begin
                            r_state <= S_HDR;
                        end
                    end
                    S_DONE:  r_state <= S_DONE;
                    default: r_state <= S_HDR;
                endcase
            end

            if (w_oob_done) begin
                r_oob_valid <= 1'b1;
                r_oob_type  <= r_cur_type;
                r_oob_len   <= w_done_len;
                r_oob_w0    <= w_w0;
                r_oob_w1    <= w_w1;
                r_oob_w2    <= w_w2;
                if (r_cur_type == 8'h02) begin
                    r_index_count <= r_index_count + 16'd1;
                end
            end

            // EOF ignores its size field and reports an empty payload.
            if (w_eof_done) begin
                r_oob_valid   <= 1'b1;
                r_oob_type    <= r_cur_type;
                r_oob_len     <= '0;
                r_oob_w0      <= '0;
                r_oob_w1      <= '0;
                r_oob_w2      <= '0;
                r_stream_done <= 1'b1;
            end

            if (w_pos_mismatch) begin
                r_pos_error <= 1'b1;
            end
        end
    end

    assign flux_out_data   = r_flux_data;
    assign flux_out_valid  = r_flux_valid;
    assign oob_valid       = r_oob_valid;
    assign oob_type        = r_oob_type;
    assign oob_len         = r_oob_len;
    assign oob_word0       = r_oob_w0;
    assign oob_word1       = r_oob_w1;
    assign oob_word2       = r_oob_w2;
    assign stream_position = r_stream_position;
    assign index_count     = r_index_count;
    assign stream_done     = r_stream_done;
    assign ovf_error       = r_ovf_error;

`ifdef KF_DEC_POS_CHECK_EN
    assign pos_error = r_pos_error;
`else
    assign pos_error = 1'b0;
`endif

endmodule

// File: tb/tb_kf_stream_decoder.sv
// Testbench for kf_stream_decoder. A stream-level reference model parses each
// committed block of bytes and queues the expected flux words and OOB events;
// the DUT is driven with randomized valid/ready and its outputs are compared.
module tb_kf_stream_decoder;

    localparam int FW = 20;
    localparam longint MAXF = (longint'(1) << FW) - 1;

    typedef struct {
        logic [7:0]  t;
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
    } oob_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_clear;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] flux_out_data;
    logic          flux_out_valid;
    logic          flux_out_ready;
    logic          oob_valid;
    logic [7:0]    oob_type;
    logic [15:0]   oob_len;
    logic [31:0]   oob_word0, oob_word1, oob_word2;
    logic [31:0]   stream_position;
    logic [15:0]   index_count;
    logic          stream_done, pos_error, ovf_error;

    int tests = 0;
    int fails = 0;

    byte unsigned  blk_q[$];
    byte unsigned  stim_q[$];
    logic [FW-1:0] exp_flux_q[$];
    oob_t          exp_oob_q[$];

    // reference model state
    int unsigned   m_pos;
    longint        m_acc;
    logic [15:0]   m_idx;
    bit            m_done, m_ovf, m_perr;

    kf_stream_decoder #(.FLUX_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .dec_clear(dec_clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flux_out_data(flux_out_data), .flux_out_valid(flux_out_valid),
        .flux_out_ready(flux_out_ready),
        .oob_valid(oob_valid), .oob_type(oob_type), .oob_len(oob_len),
        .oob_word0(oob_word0), .oob_word1(oob_word1), .oob_word2(oob_word2),
        .stream_position(stream_position), .index_count(index_count),
        .stream_done(stream_done), .pos_error(pos_error), .ovf_error(ovf_error)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos = 0; m_acc = 0; m_idx = 0; m_done = 0; m_ovf = 0; m_perr = 0;
        exp_flux_q.delete(); exp_oob_q.delete();
    endtask

    task automatic model_flux(input longint v);
        longint s;
        s = m_acc + v;
        if (s > MAXF) begin
            exp_flux_q.push_back(FW'(MAXF));
            m_ovf = 1;
        end else begin
            exp_flux_q.push_back(FW'(s));
        end
        m_acc = 0;
    endtask

    // Parse complete blocks in blk_q, update the model, append to stim_q.
    task automatic commit_blk();
        int i, n, len;
        byte unsigned h, t;
        logic [31:0] w[3];
        oob_t e;
        n = blk_q.size();
        i = 0;
        while (i < n) begin
            h = blk_q[i];
            if (m_done) begin
                i += 1;
            end else if (h <= 8'h07) begin
                model_flux(longint'(h & 8'h07) * 256 + longint'(blk_q[i+1]));
                m_pos += 2; i += 2;
            end else if (h == 8'h08) begin
                m_pos += 1; i += 1;
            end else if (h == 8'h09) begin
                m_pos += 2; i += 2;
            end else if (h == 8'h0A) begin
                m_pos += 3; i += 3;
            end else if (h == 8'h0B) begin
                m_acc += 65536; m_pos += 1; i += 1;
            end else if (h == 8'h0C) begin
                model_flux(longint'(blk_q[i+1]) * 256 + longint'(blk_q[i+2]));
                m_pos += 3; i += 3;
            end else if (h == 8'h0D) begin
                t   = blk_q[i+1];
                len = int'(blk_q[i+2]) + 256 * int'(blk_q[i+3]);
                w[0] = 0; w[1] = 0; w[2] = 0;
                if (t == 8'h0D) begin
                    e.t = t; e.len = 0; e.w0 = 0; e.w1 = 0; e.w2 = 0;
                    exp_oob_q.push_back(e);
                    m_done = 1;
                    i += 4;
                end else begin
                    for (int k = 0; k < len && k < 12; k++)
                        w[k/4] = w[k/4] | (32'(blk_q[i+4+k]) << (8 * (k % 4)));
                    e.t = t; e.len = 16'(len); e.w0 = w[0]; e.w1 = w[1]; e.w2 = w[2];
                    exp_oob_q.push_back(e);
                    if (t == 8'h02) m_idx += 1;
`ifdef KF_DEC_POS_CHECK_EN
                    if (t >= 8'h01 && t <= 8'h03 && len >= 4 && w[0] != m_pos) m_perr = 1;
`endif
                    i += 4 + len;
                end
            end else begin
                model_flux(longint'(h));
                m_pos += 1; i += 1;
            end
        end
        foreach (blk_q[j]) stim_q.push_back(blk_q[j]);
        blk_q.delete();
    endtask

    task automatic add_oob(input logic [7:0] t, input int len, input logic [31:0] w0v);
        blk_q.push_back(8'h0D);
        blk_q.push_back(t);
        blk_q.push_back(len[7:0]);
        blk_q.push_back(len[15:8]);
        for (int k = 0; k < len; k++) begin
            if (k < 4) blk_q.push_back(w0v[8*k +: 8]);
            else       blk_q.push_back(8'($urandom_range(0, 255)));
        end
        commit_blk();
    endtask

    // Drive stim_q into the DUT and check every flux word and OOB event.
    task automatic run_stream(input int rdy_pct);
        int idx, idle, budget, n;
        oob_t e;
        logic [FW-1:0] ef;
        idx = 0; idle = 0; budget = 0; n = stim_q.size();
        while (idle < 6 && budget < 20000) begin
            if (idx < n) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = stim_q[idx];
                flux_out_ready = ($urandom_range(1, 100) <= rdy_pct);
            end else begin
                in_valid = 1'b0;
                flux_out_ready = 1'b1;
            end
            @(negedge clk);
            if (flux_out_valid && flux_out_ready) begin
                tests++;
                if (exp_flux_q.size() == 0) begin
                    fails++;
                    $display("FAIL flux_extra: got %0h, required no flux word", flux_out_data);
                end else begin
                    ef = exp_flux_q.pop_front();
                    if (flux_out_data !== ef) begin
                        fails++;
                        $display("FAIL flux_data: got %0h required %0h", flux_out_data, ef);
                    end
                end
            end
            if (oob_valid) begin
                tests++;
                if (exp_oob_q.size() == 0) begin
                    fails++;
                    $display("FAIL oob_extra: got type %0h, required no OOB event", oob_type);
                end else begin
                    e = exp_oob_q.pop_front();
                    if (oob_type !== e.t || oob_len !== e.len || oob_word0 !== e.w0 ||
                        oob_word1 !== e.w1 || oob_word2 !== e.w2) begin
                        fails++;
                        $display("FAIL oob_fields: got %0h/%0h/%0h/%0h/%0h required %0h/%0h/%0h/%0h/%0h",
                                 oob_type, oob_len, oob_word0, oob_word1, oob_word2,
                                 e.t, e.len, e.w0, e.w1, e.w2);
                    end
                end
            end
            if (in_valid && in_ready) idx++;
            if (idx >= n && !flux_out_valid) idle++;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        tests++;
        if (budget >= 20000 || exp_flux_q.size() != 0 || exp_oob_q.size() != 0) begin
            fails++;
            $display("FAIL stream_drain: cycles %0d, flux left %0d, oob left %0d, required all drained",
                     budget, exp_flux_q.size(), exp_oob_q.size());
        end
        stim_q.delete();
    endtask

    task automatic check_status(input string tag);
        tests++;
        if (stream_position !== m_pos || index_count !== m_idx || stream_done !== m_done ||
            ovf_error !== m_ovf || pos_error !== m_perr) begin
            fails++;
            $display("FAIL %s status: got pos %0d idx %0d done %0b ovf %0b perr %0b required %0d %0d %0b %0b %0b",
                     tag, stream_position, index_count, stream_done, ovf_error, pos_error,
                     m_pos, m_idx, m_done, m_ovf, m_perr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dec_clear = 1'b0; in_valid = 1'b1; in_data = 8'h64; flux_out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready: got %0b required 0", in_ready);
        end
        tests++;
        if (flux_out_valid !== 1'b0 || oob_valid !== 1'b0 || flux_out_data !== '0 ||
            oob_word0 !== 32'h0 || oob_type !== 8'h0) begin
            fails++;
            $display("FAIL reset_outputs: got fv %0b ov %0b fd %0h w0 %0h t %0h required all 0",
                     flux_out_valid, oob_valid, flux_out_data, oob_word0, oob_type);
        end
        check_status("reset");
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flux1_latency();
        logic [FW-1:0] ef;
        blk_q.push_back(8'h64); commit_blk(); stim_q.delete();
        ef = exp_flux_q.pop_front();
        flux_out_ready = 1'b1; in_data = 8'h64; in_valid = 1'b1;
        tests++;
        if (flux_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_pre_valid: got %0b required 0", flux_out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (flux_out_valid !== 1'b1 || flux_out_data !== ef) begin
            fails++;
            $display("FAIL lat_flux1: got v %0b d %0h required v 1 d %0h", flux_out_valid, flux_out_data, ef);
        end
        check_status("flux1");
        @(posedge clk); #1;
        tests++;
        if (flux_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_drop: got %0b required 0", flux_out_valid);
        end
    endtask

    task automatic test_flux2_flux3();
        blk_q = {8'h03, 8'h20}; commit_blk();
        blk_q = {8'h0C, 8'h12, 8'h34}; commit_blk();
        blk_q = {8'h00, 8'h00}; commit_blk();
        blk_q = {8'h07, 8'hFF}; commit_blk();
        run_stream(80);
        check_status("flux23");
    endtask

    task automatic test_ovl_nop();
        blk_q = {8'h0B, 8'h0B, 8'h0E}; commit_blk();
        blk_q = {8'h0A, 8'hAA, 8'hBB, 8'h09, 8'hCC, 8'h08}; commit_blk();
        run_stream(100);
        check_status("ovl_nop");
    endtask

    task automatic test_oob_index();
        blk_q = {8'h20, 8'h21, 8'h22}; commit_blk();
        add_oob(8'h02, 12, m_pos);
        add_oob(8'h04, 0, 32'h0);
        add_oob(8'h03, 3, 32'h00ABCDEF);
        add_oob(8'h01, 20, m_pos);
        run_stream(100);
        check_status("oob_good");
        add_oob(8'h02, 12, m_pos + 4);
        run_stream(100);
        check_status("oob_bad");
    endtask

    task automatic test_stall();
        logic [FW-1:0] e1, e2;
        blk_q = {8'h20, 8'h30}; commit_blk(); stim_q.delete();
        e1 = exp_flux_q.pop_front();
        e2 = exp_flux_q.pop_front();
        flux_out_ready = 1'b0; in_data = 8'h20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h30;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (flux_out_valid !== 1'b1 || flux_out_data !== e1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: got v %0b d %0h rdy %0b required 1 %0h 0",
                         flux_out_valid, flux_out_data, in_ready, e1);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (stream_position !== m_pos - 1) begin
            fails++;
            $display("FAIL stall_pos: got %0d required %0d", stream_position, m_pos - 1);
        end
        flux_out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready: got %0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (flux_out_valid !== 1'b1 || flux_out_data !== e2) begin
            fails++;
            $display("FAIL stall_second: got v %0b d %0h required 1 %0h", flux_out_valid, flux_out_data, e2);
        end
        check_status("stall");
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 15; k++) blk_q.push_back(8'h0B);
        blk_q.push_back(8'h0C); blk_q.push_back(8'hFF); blk_q.push_back(8'hFF);
        commit_blk();
        run_stream(90);
        check_status("ovf_edge");
        for (int k = 0; k < 16; k++) blk_q.push_back(8'h0B);
        blk_q.push_back(8'h0E);
        commit_blk();
        blk_q = {8'h0B, 8'h50}; commit_blk();
        run_stream(90);
        check_status("ovf_sat");
    endtask

    task automatic test_random();
        int kind, len;
        logic [7:0] t;
        for (int b = 0; b < 200; b++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: blk_q.push_back(8'($urandom_range(14, 255)));
                4: begin
                    blk_q.push_back(8'($urandom_range(0, 7)));
                    blk_q.push_back(8'($urandom_range(0, 255)));
                end
                5: begin
                    blk_q.push_back(8'h0C);
                    blk_q.push_back(8'($urandom_range(0, 255)));
                    blk_q.push_back(8'($urandom_range(0, 255)));
                end
                6: begin
                    len = $urandom_range(0, 2);
                    blk_q.push_back(8'(8 + len));
                    for (int k = 0; k < len; k++) blk_q.push_back(8'($urandom_range(0, 255)));
                end
                7: blk_q.push_back(8'h0B);
                default: ;
            endcase
            if (kind >= 8) begin
                t   = 8'($urandom_range(0, 4));
                len = $urandom_range(0, 16);
                if ($urandom_range(0, 3) != 0) add_oob(t, len, m_pos);
                else                           add_oob(t, len, $urandom());
            end else begin
                commit_blk();
            end
        end
        run_stream(70);
        check_status("random");
    endtask

    task automatic test_eof_clear();
        blk_q = {8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h50, 8'h0C, 8'h11}; commit_blk();
        run_stream(100);
        check_status("eof");
        dec_clear = 1'b1; in_valid = 1'b1; in_data = 8'h0E;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_in_ready: got %0b required 0", in_ready);
        end
        @(posedge clk); #1;
        dec_clear = 1'b0; in_valid = 1'b0;
        model_reset();
        check_status("clear");
        tests++;
        if (flux_out_valid !== 1'b0 || oob_type !== 8'h0 || oob_word0 !== 32'h0) begin
            fails++;
            $display("FAIL clear_outputs: got fv %0b t %0h w0 %0h required 0", flux_out_valid, oob_type, oob_word0);
        end
        blk_q = {8'h64, 8'h01, 8'h02}; commit_blk();
        run_stream(100);
        check_status("after_clear");
    endtask

    initial begin
        test_reset();
        test_flux1_latency();
        test_flux2_flux3();
        test_ovl_nop();
        test_oob_index();
        test_stall();
        test_overflow();
        test_random();
        test_eof_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
